// File: rtl/cpu_trace_monitor.sv
// Bounded-run CPU observer: classifies each sample as retire/stall/redirect, keeps saturating
// statistics and (when TRACE_BUF_EN is defined) a readable ring buffer of retired instructions.
module cpu_trace_monitor #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned INST_W     = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned MAX_CYCLES = 100,
    parameter int unsigned HALT_CNT   = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        pc,
    input  logic [INST_W-1:0]        inst,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [INST_W-1:0]        rd_inst,
    output logic [1:0]               state,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         redirect_cnt,
    output logic [$clog2(DEPTH):0]   trace_cnt,
    output logic                     wrapped,
    output logic                     done,
    output logic                     halted
);

    localparam int unsigned RunW = $clog2(HALT_CNT + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cycle_q;
    logic [CNT_W-1:0]  retire_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  redirect_q;
    logic [RunW-1:0]   run_q;
    logic              first_q;
    logic              done_q;
    logic              halted_q;
    logic [ADDR_W-1:0] prev_pc_q;

    logic              sampling;
    logic              clear_run;
    logic              is_stall;
    logic              is_retire;
    logic              is_redirect;
    logic [ADDR_W-1:0] seq_pc;
    logic [CNT_W-1:0]  cycle_nxt;
    logic [RunW-1:0]   run_nxt;
    logic              hit_budget;
    logic              hit_halt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        sampling    = (state_q == StRun);
        clear_run   = (state_q != StRun) && start;
        seq_pc      = prev_pc_q + ADDR_W'(4);
        is_stall    = sampling && !first_q && (pc == prev_pc_q);
        is_retire   = sampling && !is_stall;
        is_redirect = is_retire && !first_q && (pc != seq_pc);
        cycle_nxt   = sat_inc(cycle_q);
        // The stall run never exceeds HALT_CNT because reaching it ends the run.
        run_nxt     = is_stall ? run_q + RunW'(1) : '0;
        hit_budget  = (cycle_nxt == CNT_W'(MAX_CYCLES));
        hit_halt    = (run_nxt == RunW'(HALT_CNT));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cycle_q    <= '0;
            retire_q   <= '0;
            stall_q    <= '0;
            redirect_q <= '0;
            run_q      <= '0;
            first_q    <= 1'b0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
            prev_pc_q  <= '0;
        end else if (clear_run) begin
            state_q    <= StRun;
            cycle_q    <= '0;
            retire_q   <= '0;
            stall_q    <= '0;
            redirect_q <= '0;
            run_q      <= '0;
            first_q    <= 1'b1;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else if (sampling) begin
            cycle_q   <= cycle_nxt;
            run_q     <= run_nxt;
            first_q   <= 1'b0;
            prev_pc_q <= pc;
            if (is_retire) begin
                retire_q <= sat_inc(retire_q);
            end
            if (is_stall) begin
                stall_q <= sat_inc(stall_q);
            end
            if (is_redirect) begin
                redirect_q <= sat_inc(redirect_q);
            end
            if (hit_budget || hit_halt) begin
                state_q  <= StDone;
                done_q   <= hit_budget;
                halted_q <= hit_halt;
            end
        end
    end

    assign state        = state_q;
    assign cycle_cnt    = cycle_q;
    assign retire_cnt   = retire_q;
    assign stall_cnt    = stall_q;
    assign redirect_cnt = redirect_q;
    assign done         = done_q;
    assign halted       = halted_q;

`ifdef TRACE_BUF_EN
    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned EntryW  = ADDR_W + INST_W;
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    logic [EntryW-1:0] mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   wr_ptr_nxt;
    logic [PtrW:0]     tcnt_q;
    logic [PtrW:0]     tcnt_nxt;
    logic              wrapped_q;
    logic              wrapped_nxt;
    logic [PtrW-1:0]   rd_addr;
    logic [EntryW-1:0] rd_data_nxt;
    logic [EntryW-1:0] rd_q;

    always_comb begin
        wr_ptr_nxt  = wr_ptr_q;
        tcnt_nxt    = tcnt_q;
        wrapped_nxt = wrapped_q;
        if (clear_run) begin
            wr_ptr_nxt  = '0;
            tcnt_nxt    = '0;
            wrapped_nxt = 1'b0;
        end else if (is_retire) begin
            wr_ptr_nxt = wr_ptr_q + PtrW'(1);
            if (tcnt_q == FullCnt) begin
                wrapped_nxt = 1'b1;
            end else begin
                tcnt_nxt = tcnt_q + (PtrW + 1)'(1);
            end
        end
        // Index relative to the oldest entry as it stands after this edge; a full count
        // truncates to zero, which is exactly the oldest slot.
        rd_addr     = wr_ptr_nxt - tcnt_nxt[PtrW-1:0] + rd_idx;
        rd_data_nxt = '0;
        if ({1'b0, rd_idx} < tcnt_nxt) begin
            rd_data_nxt = (is_retire && (rd_addr == wr_ptr_q)) ? {pc, inst} : mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            tcnt_q    <= '0;
            wrapped_q <= 1'b0;
            rd_q      <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_nxt;
            tcnt_q    <= tcnt_nxt;
            wrapped_q <= wrapped_nxt;
            rd_q      <= rd_data_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && is_retire) begin
            mem[wr_ptr_q] <= {pc, inst};
        end
    end

    assign rd_pc     = rd_q[EntryW-1:INST_W];
    assign rd_inst   = rd_q[INST_W-1:0];
    assign trace_cnt = tcnt_q;
    assign wrapped   = wrapped_q;
`else
    logic unused_trace;

    assign unused_trace = ^{rd_idx, inst};
    assign rd_pc        = '0;
    assign rd_inst      = '0;
    assign trace_cnt    = '0;
    assign wrapped      = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Randomised self-checking bench for cpu_trace_monitor against a queue-based run model.
module tb_cpu_trace_monitor;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXC  = 10;
    localparam int unsigned HALT  = 8;
`ifdef TRACE_BUF_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  rd_idx;
    logic [31:0] rd_pc;
    logic [31:0] rd_inst;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] redirect_cnt;
    logic [2:0]  trace_cnt;
    logic        wrapped;
    logic        done;
    logic        halted;

    cpu_trace_monitor #(
        .ADDR_W    (32),
        .INST_W    (32),
        .DEPTH     (DEPTH),
        .MAX_CYCLES(MAXC),
        .HALT_CNT  (HALT),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pc          (pc),
        .inst        (inst),
        .rd_idx      (rd_idx),
        .rd_pc       (rd_pc),
        .rd_inst     (rd_inst),
        .state       (state),
        .cycle_cnt   (cycle_cnt),
        .retire_cnt  (retire_cnt),
        .stall_cnt   (stall_cnt),
        .redirect_cnt(redirect_cnt),
        .trace_cnt   (trace_cnt),
        .wrapped     (wrapped),
        .done        (done),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Run model: plain counts plus a queue holding the newest DEPTH retirements.
    int          m_state;
    int          m_cycle, m_retire, m_stall, m_redirect, m_run, m_written;
    bit          m_first, m_done, m_halted;
    logic [31:0] m_prev;
    logic [63:0] m_trace[$];

    wire [135:0] dut_status = {state, cycle_cnt, retire_cnt, stall_cnt, redirect_cnt,
                               trace_cnt, wrapped, done, halted};

    function automatic void model_clear();
        m_cycle = 0; m_retire = 0; m_stall = 0; m_redirect = 0; m_run = 0; m_written = 0;
        m_done = 1'b0; m_halted = 1'b0; m_first = 1'b0;
        m_trace.delete();
    endfunction

    function automatic void model_reset();
        model_clear();
        m_state = 0;
        m_prev  = '0;
    endfunction

    function automatic void model_edge(input bit s, input logic [31:0] p, input logic [31:0] i);
        if (m_state != 1) begin
            if (s) begin
                model_clear();
                m_state = 1;
                m_first = 1'b1;
            end
            return;
        end
        m_cycle++;
        if (!m_first && p == m_prev) begin
            m_stall++;
            m_run++;
        end else begin
            if (!m_first && p != m_prev + 32'd4) m_redirect++;
            m_retire++;
            m_run = 0;
            m_trace.push_back({p, i});
            m_written++;
            if (m_trace.size() > DEPTH) void'(m_trace.pop_front());
        end
        m_first = 1'b0;
        m_prev  = p;
        if (m_cycle == MAXC) m_done = 1'b1;
        if (m_run == HALT) m_halted = 1'b1;
        if (m_done || m_halted) m_state = 2;
    endfunction

    function automatic logic [135:0] exp_status();
        logic [2:0] tc;
        logic       wr;
        tc = TRACE_ON ? 3'(m_trace.size()) : 3'd0;
        wr = TRACE_ON && (m_written > DEPTH);
        return {2'(m_state), 32'(m_cycle), 32'(m_retire), 32'(m_stall), 32'(m_redirect),
                tc, wr, m_done, m_halted};
    endfunction

    function automatic logic [63:0] exp_read(input int idx);
        if (TRACE_ON && idx < m_trace.size()) return m_trace[idx];
        return 64'd0;
    endfunction

    task automatic tick(input bit s, input logic [31:0] p, input logic [31:0] i);
        start = s;
        pc    = p;
        inst  = i;
        @(posedge clk);
        if (rst) model_edge(s, p, i);
        else model_reset();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) tick(1'b1, $urandom, $urandom);
        if (dut_status !== exp_status()) begin
            bad++; $display("FAIL reset_status got=%h want=%h", dut_status, exp_status());
        end
        total++;
        if ({rd_pc, rd_inst} !== 64'd0) begin
            bad++; $display("FAIL reset_rd got=%h want=0", {rd_pc, rd_inst});
        end
        total++;
        if (state !== 2'd0) begin
            bad++; $display("FAIL reset_state got=%0d want=0", state);
        end
        total++;
        rst = 1'b1;
        tick(1'b0, 32'd0, 32'd0);
        if (dut_status !== exp_status()) begin
            bad++; $display("FAIL idle_hold got=%h want=%h", dut_status, exp_status());
        end
        total++;
    endtask

    task automatic test_budget();
        tick(1'b1, 32'd0, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 32'(4 * k), $urandom);
            if (dut_status !== exp_status()) begin
                bad++; $display("FAIL budget_step%0d got=%h want=%h", k, dut_status, exp_status());
            end
            total++;
        end
        if ({state, done, halted, cycle_cnt, retire_cnt, stall_cnt, redirect_cnt}
            !== {2'd2, 1'b1, 1'b0, 32'd10, 32'd10, 32'd0, 32'd0}) begin
            bad++; $display("FAIL budget_end got st=%0d d=%0d h=%0d cyc=%0d ret=%0d want 2 1 0 10 10",
                            state, done, halted, cycle_cnt, retire_cnt);
        end
        total++;
        if (trace_cnt !== (TRACE_ON ? 3'd4 : 3'd0) || wrapped !== TRACE_ON) begin
            bad++; $display("FAIL budget_trace got cnt=%0d wrap=%0d", trace_cnt, wrapped);
        end
        total++;
        for (int idx = 0; idx < 4; idx++) begin
            rd_idx = 2'(idx);
            tick(1'b0, 32'd0, 32'd0);
            if ({rd_pc, rd_inst} !== exp_read(idx)) begin
                bad++; $display("FAIL budget_rd%0d got=%h want=%h", idx, {rd_pc, rd_inst}, exp_read(idx));
            end
            total++;
        end
        if (rd_pc !== (TRACE_ON ? 32'h24 : 32'h0)) begin
            bad++; $display("FAIL budget_newest got=%h want=%h", rd_pc, TRACE_ON ? 32'h24 : 32'h0);
        end
        total++;
    endtask

    task automatic test_stall_redirect();
        logic [31:0] pcs [10] = '{32'h0, 32'h4, 32'h4, 32'h20, 32'h24,
                                  32'h24, 32'h24, 32'h24, 32'h24, 32'h24};
        logic [31:0] want [4] = '{32'h0, 32'h4, 32'h20, 32'h24};
        tick(1'b1, 32'd0, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, pcs[k], 32'(k));
            if (k == 4 && {retire_cnt, stall_cnt, redirect_cnt} !== {32'd4, 32'd1, 32'd1}) begin
                bad++; $display("FAIL sr_counts got ret=%0d stl=%0d red=%0d want 4 1 1",
                                retire_cnt, stall_cnt, redirect_cnt);
            end
            if (k == 4) total++;
        end
        if (dut_status !== exp_status()) begin
            bad++; $display("FAIL sr_end got=%h want=%h", dut_status, exp_status());
        end
        total++;
        if (trace_cnt !== (TRACE_ON ? 3'd4 : 3'd0) || wrapped !== 1'b0 || stall_cnt !== 32'd6) begin
            bad++; $display("FAIL sr_full got cnt=%0d wrap=%0d stl=%0d", trace_cnt, wrapped, stall_cnt);
        end
        total++;
        for (int idx = 0; idx < 4; idx++) begin
            rd_idx = 2'(idx);
            tick(1'b0, 32'd0, 32'd0);
            if (rd_pc !== (TRACE_ON ? want[idx] : 32'd0)) begin
                bad++; $display("FAIL sr_rd%0d got=%h want=%h", idx, rd_pc, TRACE_ON ? want[idx] : 32'd0);
            end
            total++;
        end
    endtask

    task automatic test_halt();
        tick(1'b1, 32'd0, 32'd0);
        for (int k = 0; k < 9; k++) tick(1'b0, 32'h10, 32'h77);
        if ({state, done, halted, cycle_cnt, retire_cnt, stall_cnt}
            !== {2'd2, 1'b0, 1'b1, 32'd9, 32'd1, 32'd8}) begin
            bad++; $display("FAIL halt_only got st=%0d d=%0d h=%0d cyc=%0d ret=%0d stl=%0d want 2 0 1 9 1 8",
                            state, done, halted, cycle_cnt, retire_cnt, stall_cnt);
        end
        total++;
        tick(1'b1, 32'd0, 32'd0);
        tick(1'b0, 32'h0, 32'h1);
        for (int k = 0; k < 9; k++) tick(1'b0, 32'h10, 32'h2);
        if ({done, halted, cycle_cnt, retire_cnt, stall_cnt, redirect_cnt}
            !== {1'b1, 1'b1, 32'd10, 32'd2, 32'd8, 32'd1}) begin
            bad++; $display("FAIL halt_both got d=%0d h=%0d cyc=%0d ret=%0d stl=%0d red=%0d want 1 1 10 2 8 1",
                            done, halted, cycle_cnt, retire_cnt, stall_cnt, redirect_cnt);
        end
        total++;
        if (dut_status !== exp_status()) begin
            bad++; $display("FAIL halt_status got=%h want=%h", dut_status, exp_status());
        end
        total++;
    endtask

    task automatic test_reset_midrun();
        tick(1'b1, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) tick(1'b0, 32'(4 * k), $urandom);
        rst = 1'b0;
        tick(1'b0, 32'h10, 32'h5);
        rst = 1'b1;
        if (dut_status !== exp_status() || state !== 2'd0 || cycle_cnt !== 32'd0) begin
            bad++; $display("FAIL midrun_reset got=%h want=%h", dut_status, exp_status());
        end
        total++;
        if ({rd_pc, rd_inst} !== 64'd0) begin
            bad++; $display("FAIL midrun_rd got=%h want=0", {rd_pc, rd_inst});
        end
        total++;
        tick(1'b1, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) tick(1'b0, 32'h100 + 32'(4 * k), $urandom);
        if (cycle_cnt !== 32'd3 || state !== 2'd1) begin
            bad++; $display("FAIL restart got cyc=%0d st=%0d want 3 1", cycle_cnt, state);
        end
        total++;
        for (int k = 0; k < 7; k++) tick(1'b0, 32'h200, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] cur;
        int          r;
        for (int run = 0; run < 8; run++) begin
            cur = $urandom & 32'hFFFF_FFFC;
            tick(1'b1, $urandom, $urandom);
            for (int c = 0; c < MAXC + 2 && m_state == 1; c++) begin
                r = $urandom_range(0, 9);
                if (r < run + 2) cur = cur;
                else if (r < 8) cur = cur + 32'd4;
                else cur = $urandom;
                rd_idx = 2'($urandom);
                tick(($urandom_range(0, 4) == 0), cur, $urandom);
                if (dut_status !== exp_status()) begin
                    bad++; $display("FAIL rand_run%0d_c%0d got=%h want=%h", run, c, dut_status, exp_status());
                end
                total++;
            end
            for (int idx = 0; idx < 4; idx++) begin
                rd_idx = 2'(idx);
                tick(1'b0, $urandom, $urandom);
                if ({rd_pc, rd_inst} !== exp_read(idx)) begin
                    bad++; $display("FAIL rand_rd%0d_%0d got=%h want=%h", run, idx, {rd_pc, rd_inst}, exp_read(idx));
                end
                total++;
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; pc = '0; inst = '0; rd_idx = '0;
        model_reset();
        test_reset();
        test_budget();
        test_stall_redirect();
        test_halt();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/cpu_trace_monitor.md
# cpu_trace_monitor

Synthesizable, parametrised run monitor for the pipelined CPU. It samples the CPU's `pc`/`inst` every cycle during a bounded run and classifies each cycle as retire, stall or redirect. It keeps saturating statistics counters and records retired instructions in a ring trace buffer that can be read back. It detects end of run either by cycle budget or by PC-stuck halt, and replaces fixed-length, print-based observation with on-chip checkable results.

## Interface
- `ADDR_W`, 32, PC width
- `INST_W`, 32, instruction width
- `DEPTH`, 16, trace entries; power of two, ≥2
- `MAX_CYCLES`, 100, samples per run; ≥1
- `HALT_CNT`, 8, consecutive stalls that declare halt; ≥1
- `CNT_W`, 32, statistics counter width
- `clk  in  1  clock; all state changes on rising edge`
- `rst  in  1  reset; synchronous, active-low`
- `start  in  1  begin run; honoured in IDLE or DONE only`
- `pc  in  ADDR_W  CPU fetch PC`
- `inst  in  INST_W  CPU instruction at pc`
- `rd_idx  in  $clog2(DEPTH)  trace read index; 0 = oldest valid entry`
- `rd_pc  out  ADDR_W  trace PC at rd_idx, registered`
- `rd_inst  out  INST_W  trace instruction at rd_idx, registered`
- `state  out  2  0=IDLE, 1=RUN, 2=DONE`
- `cycle_cnt, retire_cnt, stall_cnt, redirect_cnt  out  CNT_W  run statistics`
- `trace_cnt  out  $clog2(DEPTH)+1  valid trace entries`
- `wrapped  out  1  trace buffer has overwritten an entry`
- `done  out  1  run ended on cycle budget`
- `halted  out  1  run ended on PC-stuck`

## Operation
- **Reset** (`rst`=0 at edge, any state): state=IDLE. All counters, `trace_cnt`, `wrapped`, `done`, `halted`, `rd_pc`, `rd_inst`, write pointer, stall run and first-sample flag are 0. Trace RAM contents are not cleared.
- **IDLE**: `start`=1 → RUN. On entry, clear all counters and flags, `trace_cnt`, the write pointer and the stall run, and set the first-sample flag.
- **RUN**: each edge is one sample; `cycle_cnt`+1.
  - First sample: retire. Does not count as a redirect.
  - Otherwise `pc`==prev_pc: stall. `stall_cnt`+1, stall run +1, no trace write.
  - Otherwise: retire. `retire_cnt`+1, stall run cleared. If `pc` ≠ prev_pc+4 (mod 2^ADDR_W), `redirect_cnt`+1.
  - Every retire writes {pc, inst} at the write pointer. The pointer increments mod DEPTH. `trace_cnt` saturates at DEPTH. A write while `trace_cnt`==DEPTH sets `wrapped`.
  - prev_pc is updated every sample.
  - `start` is ignored in RUN.
- **End of run**:
  - Updated `cycle_cnt`==MAX_CYCLES → DONE, `done`=1.
  - Updated stall run==HALT_CNT → DONE, `halted`=1.
  - Both on the same edge → both flags set.
- **DONE**: all outputs hold. `start`=1 → RUN with the same clear as from IDLE.
- **Counters**: saturate at 2^CNT_W−1 and never wrap.
- **Readout**: physical address = (wr_ptr − trace_cnt + rd_idx) mod DEPTH. Readout is valid in every state. When rd_idx ≥ `trace_cnt`, `rd_pc`/`rd_inst` = 0.

## Timing
- Transition IDLE→RUN occurs at the edge where `start`=1. The first sample is taken at the next edge.
- A run takes exactly min(MAX_CYCLES, halt point) samples.
- Counter, flag and state outputs reflect a sample from the cycle after its edge.
- Readout latency is 1 cycle: `rd_idx` sampled at edge N appears on `rd_pc`/`rd_inst` after edge N.
- A trace write and a read of the same entry on the same edge return the new data.
- Reset has priority over `start` and over sampling.

## Configuration
- `TRACE_BUF_EN` defined: ring buffer, pointer and readout are built as specified.
- Not defined: no storage is built. `rd_pc`, `rd_inst`, `trace_cnt` and `wrapped` are constant 0, and ports are unchanged. Counters, FSM, `done` and `halted` are identical in both builds.

## Test plan
- **Reset**: hold `rst`=0 two cycles with random pc → state=0, all counters 0, done=halted=wrapped=0, rd_pc=0.
- **Cycle budget** (MAX_CYCLES=10): start, pc=0,4,…,0x24 → done=1, state=2, cycle=retire=10, stall=redirect=0, trace_cnt=10, rd_idx=3 → rd_pc=0xC after 1 cycle.
- **Stall and redirect**: pc=0,4,4,0x20,0x24 → retire=4, stall=1, redirect=1, trace entries 0,4,0x20,0x24.
- **Halt** (HALT_CNT=8, MAX_CYCLES=100): pc=0,0x10 then 0x10 held → halted=1, done=0, stall=8, cycle=10, retire=2.
- **Wrap** (DEPTH=4): pc=0,4,…,0x14 → trace_cnt=4, wrapped=1, rd_idx 0..3 → 8,0xC,0x10,0x14. Repeat without `TRACE_BUF_EN` → rd_pc=0, trace_cnt=0.
- **Reset mid-run and restart**: `rst`=0 on sample 5 → IDLE, all zero. `start` again → fresh run with cycle_cnt counted from 0.
